// File: rtl/ghostchip_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, command codes, VRAM geometry.
package ghostchip_pkg;

    localparam int VRAM_W = 128;
    localparam int VRAM_H = 64;
    localparam int HPOS_W = 7;
    localparam int VPOS_W = 6;

    localparam logic CMD_DRAW = 1'b0;
    localparam logic CMD_CLS  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PIX_RD,
        PIX_WR,
        CLR_RD,
        CLR_WR,
        DONE
    } blit_state_e;

endpackage

// File: rtl/blit_coord.sv
// One axis of the pixel coordinate generator: origin + offset, either clipped at SIZE or wrapped modulo SIZE.
module blit_coord #(
    parameter int CW   = 7,
    parameter int SIZE = 128,
    parameter bit CLIP = 1'b1
) (
    input  logic [CW-1:0] origin_i,
    input  logic [3:0]    offset_i,
    output logic [CW-1:0] coord_o,
    output logic          in_range_o
);

    localparam int SW = CW + 1;

    logic [SW-1:0] org_m;
    logic [SW-1:0] sum;

    // Offset never exceeds 15, so one conditional subtract is enough to wrap.
    always_comb begin
        org_m      = {1'b0, origin_i} % SW'(SIZE);
        sum        = org_m + SW'(offset_i);
        coord_o    = sum[CW-1:0];
        in_range_o = 1'b1;
        if (sum >= SW'(SIZE)) begin
            if (CLIP) begin
                in_range_o = 1'b0;
            end else begin
                coord_o = CW'(sum - SW'(SIZE));
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite draw (XOR under plane mask, with collision) and clear-screen sequencer owning the CPU-side VRAM port.
//
// state  | meaning
// IDLE   | waiting for start; all port outputs held at 0
// FETCH  | drive ram_addr for the next sprite byte
// LATCH  | capture ram_dout into the shift register
// PIX_RD | current bit: read the pixel, or skip in one cycle if bit is 0 / clipped
// PIX_WR | write pixelo ^ plane back to the same pixel, accumulate collision
// CLR_RD | clear-screen read of the current pixel (partial plane mask)
// CLR_WR | clear-screen write of the current pixel
// DONE   | one-cycle completion pulse
module sprite_blitter
    import ghostchip_pkg::*;
#(
    parameter int WIDTH  = VRAM_W,
    parameter int HEIGHT = VRAM_H,
    parameter bit CLIP   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmd,
    input  logic [HPOS_W-1:0] x,
    input  logic [VPOS_W-1:0] y,
    input  logic [3:0]        n,
    input  logic [11:0]       i_addr,
    input  logic [1:0]        plane,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [11:0]       ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [HPOS_W-1:0] vram_hpos,
    output logic [VPOS_W-1:0] vram_vpos,
    output logic [1:0]        vram_pixeli,
    input  logic [1:0]        vram_pixelo,
    output logic              vram_we
);

    blit_state_e state_q, state_d;

    logic [HPOS_W-1:0] x_q, x_d;
    logic [VPOS_W-1:0] y_q, y_d;
    logic [3:0]        n_q, n_d;
    logic [11:0]       addr_q, addr_d;
    logic [1:0]        plane_q, plane_d;
    logic [7:0]        sh_q, sh_d;
    logic [2:0]        bit_q, bit_d;
    logic              half_q, half_d;
    logic [3:0]        row_q, row_d;
    logic [HPOS_W-1:0] clr_h_q, clr_h_d;
    logic [VPOS_W-1:0] clr_v_q, clr_v_d;
    logic              coll_q, coll_d;

    logic              wide;
    logic [3:0]        last_row;
    logic [4:0]        byte_off;
    logic [11:0]       byte_addr;
    logic [HPOS_W-1:0] px;
    logic [VPOS_W-1:0] py;
    logic              px_ok, py_ok;
    logic              advance;
    logic              clr_full;
    logic              clr_last;

    assign wide      = (n_q == 4'd0);
    assign last_row  = wide ? 4'd15 : n_q - 4'd1;
    assign byte_off  = wide ? {row_q, half_q} : {1'b0, row_q};
    assign byte_addr = addr_q + {7'd0, byte_off};
    assign clr_full  = (plane_q == 2'b11);
    assign clr_last  = (clr_h_q == HPOS_W'(WIDTH - 1)) && (clr_v_q == VPOS_W'(HEIGHT - 1));

    blit_coord #(.CW(HPOS_W), .SIZE(WIDTH), .CLIP(CLIP)) u_coord_x (
        .origin_i   (x_q),
        .offset_i   ({half_q, bit_q}),
        .coord_o    (px),
        .in_range_o (px_ok)
    );

    blit_coord #(.CW(VPOS_W), .SIZE(HEIGHT), .CLIP(CLIP)) u_coord_y (
        .origin_i   (y_q),
        .offset_i   (row_q),
        .coord_o    (py),
        .in_range_o (py_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            plane_q <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            row_q   <= '0;
            clr_h_q <= '0;
            clr_v_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            plane_q <= plane_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            row_q   <= row_d;
            clr_h_q <= clr_h_d;
            clr_v_q <= clr_v_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        addr_d      = addr_q;
        plane_d     = plane_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        half_d      = half_q;
        row_d       = row_q;
        clr_h_d     = clr_h_q;
        clr_v_d     = clr_v_q;
        coll_d      = coll_q;
        advance     = 1'b0;
        busy        = (state_q != IDLE) && (state_q != DONE);
        done        = (state_q == DONE);
        collision   = coll_q;
        ram_addr    = '0;
        vram_hpos   = '0;
        vram_vpos   = '0;
        vram_pixeli = '0;
        vram_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    n_d     = n;
                    addr_d  = i_addr;
                    plane_d = plane;
                    coll_d  = 1'b0;
                    bit_d   = '0;
                    half_d  = 1'b0;
                    row_d   = '0;
                    clr_h_d = '0;
                    clr_v_d = '0;
                    if (cmd == CMD_DRAW) begin
                        state_d = FETCH;
                    end else if (plane == 2'b00) begin
                        state_d = DONE;
                    end else if (plane == 2'b11) begin
                        state_d = CLR_WR;
                    end else begin
                        state_d = CLR_RD;
                    end
                end
            end
            FETCH: begin
                ram_addr = byte_addr;
                state_d  = LATCH;
            end
            LATCH: begin
                ram_addr = byte_addr;
                sh_d     = ram_dout;
                bit_d    = '0;
                state_d  = PIX_RD;
            end
            PIX_RD: begin
                if (sh_q[7] && px_ok && py_ok) begin
                    vram_hpos = px;
                    vram_vpos = py;
                    state_d   = PIX_WR;
                end else begin
                    advance = 1'b1;
                end
            end
            PIX_WR: begin
                vram_hpos   = px;
                vram_vpos   = py;
                vram_we     = 1'b1;
                vram_pixeli = vram_pixelo ^ plane_q;
                coll_d      = coll_q | (|(vram_pixelo & plane_q));
                advance     = 1'b1;
            end
            CLR_RD: begin
                vram_hpos = clr_h_q;
                vram_vpos = clr_v_q;
                state_d   = CLR_WR;
            end
            CLR_WR: begin
                vram_hpos   = clr_h_q;
                vram_vpos   = clr_v_q;
                vram_we     = 1'b1;
                vram_pixeli = clr_full ? 2'b00 : (vram_pixelo & ~plane_q);
                if (clr_last) begin
                    state_d = DONE;
                end else begin
                    if (clr_h_q == HPOS_W'(WIDTH - 1)) begin
                        clr_h_d = '0;
                        clr_v_d = clr_v_q + VPOS_W'(1);
                    end else begin
                        clr_h_d = clr_h_q + HPOS_W'(1);
                    end
                    state_d = clr_full ? CLR_WR : CLR_RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of a bit: next bit, next byte of a 16-wide row, next row, or finish.
        if (advance) begin
            if (bit_q == 3'd7) begin
                if (wide && !half_q) begin
                    half_d  = 1'b1;
                    state_d = FETCH;
                end else if (row_q == last_row) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 4'd1;
                    half_d  = 1'b0;
                    state_d = FETCH;
                end
            end else begin
                bit_d   = bit_q + 3'd1;
                sh_d    = {sh_q[6:0], 1'b0};
                state_d = PIX_RD;
            end
        end
    end

endmodule
